// File: rtl/dbus_ram.sv
// dbus_ram: memory-side responder for the dbus request/response protocol.
// One request is latched at a time, held for LATENCY cycles, then answered
// for exactly one cycle. Writes are byte-strobed into a 64-bit word array;
// reads return the whole aligned word. Out-of-range accesses read as zero,
// drop writes, and bump a saturating error counter.
//
// Handshake: a request is taken on any rising edge where the responder is
// IDLE and dreq.valid is high. The responder then ignores dreq until it is
// back in IDLE. The response is the single cycle where addr_ok and data_ok
// are both high. An initiator that leaves valid high past that cycle is
// issuing a new request.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_ram
  import dbus_pkg::*;
#(
  parameter int          ADDR_W  = 12,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        busy,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          WORDS  = 1 << ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] data_q, data_d;
  logic [15:0] err_q, err_d;
  logic        busy_q, busy_d;
  logic        resp_q, resp_d;

  logic [63:0] mem_q [0:WORDS-1];

  logic [63:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic [63:0]       rd_word;
  logic [63:0]       merged_word;
  logic              wr_en;
  logic              unused_bits;

  // Decode the latched address into a word index and a range verdict.
  always_comb begin
    offset   = addr_q - BASE;
    in_range = (addr_q >= BASE) && (offset[63:ADDR_W+3] == '0);
    word_idx = offset[ADDR_W+2:3];
  end

  // Low address bits and size never affect placement; the strobe does.
  assign unused_bits = ^{offset[2:0], dreq.size};

  // Asynchronous array read and byte merge of the latched write data.
  always_comb begin
    rd_word     = mem_q[word_idx];
    merged_word = rd_word;
    for (int i = 0; i < 8; i++) begin
      if (strobe_q[i]) merged_word[8*i +: 8] = data_q[8*i +: 8];
    end
  end

  // Commit only on the last cycle of the response, and never under reset.
  assign wr_en = (state_q == S_RESP) && in_range && (strobe_q != 8'h00) && !reset;

  // Next-state logic: accept in IDLE, count down in WAIT, answer in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (dreq.valid) begin
          addr_d   = dreq.addr;
          strobe_d = dreq.strobe;
          data_d   = dreq.data;
          cnt_d    = LAT_M1;
          state_d  = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!in_range && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    resp_d = (state_d == S_RESP);
  end

  // Control and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 64'd0;
      strobe_q <= 8'd0;
      data_q   <= 64'd0;
      err_q    <= 16'd0;
      busy_q   <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      resp_q   <= resp_d;
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[word_idx] <= merged_word;
  end

  // Response bus: zero outside the response cycle and for out-of-range accesses.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = resp_q;
    dresp.data_ok = resp_q;
    if (resp_q && in_range) dresp.data = merged_word;
  end

  assign busy      = busy_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_dbus_ram.sv
// Bench for dbus_ram: two responders (LATENCY 2 and LATENCY 1) share clock
// and reset. A transaction-level model predicts, per cycle, busy, the
// response strobes, response data and the error count from the bus the
// driver presents; a compare process checks every cycle after reset.
// Directed tests add literal expectations taken from hand calculation.
module tb_dbus_ram;
  import dbus_pkg::*;

  localparam int          AW   = 4;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          L0   = 2;
  localparam int          L1   = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_req_t   dreq0, dreq1;
  dbus_resp_t  dresp0, dresp1;
  logic        busy0, busy1;
  logic [15:0] err0, err1;

  dbus_ram #(.ADDR_W(AW), .BASE(BASE), .LATENCY(L0)) dut0 (
    .clk(clk), .reset(reset), .dreq(dreq0), .dresp(dresp0),
    .busy(busy0), .err_count(err0)
  );

  dbus_ram #(.ADDR_W(AW), .BASE(BASE), .LATENCY(L1)) dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1),
    .busy(busy1), .err_count(err1)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int key(input int i, input int k);
    return i * 1000000 + k;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? L0 : L1;
  endfunction

  function automatic dbus_req_t req_of(input int i);
    return (i == 0) ? dreq0 : dreq1;
  endfunction

  function automatic logic dok_of(input int i);
    return (i == 0) ? dresp0.data_ok : dresp1.data_ok;
  endfunction

  function automatic logic [63:0] data_of(input int i);
    return (i == 0) ? dresp0.data : dresp1.data;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] s, input logic [63:0] d);
    logic [63:0] w;
    w = old;
    for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // ---------------- model state ----------------
  bit          e_busy [int];
  bit          e_dok  [int];
  logic [63:0] e_data [int];
  logic [15:0] e_err  [int];
  logic [63:0] mmem   [int];
  int          free_at [2];
  logic [15:0] m_err   [2];
  logic [15:0] cur_err [2];
  bit          pend_v   [2];
  bit          pend_had [2];
  int          pend_cyc [2];
  int          pend_key [2];
  logic [63:0] pend_old [2];
  bit          seen_rst = 1'b0;

  // Record what acceptance of request r at cycle c must produce.
  function automatic void model_accept(input int i, input int c, input dbus_req_t r);
    int          lat;
    int          mk;
    logic [63:0] off;
    logic [63:0] old;
    logic [63:0] rdat;
    bit          inr;
    lat  = lat_of(i);
    off  = r.addr - BASE;
    inr  = (r.addr >= BASE) && ((off >> 3) < (64'd1 << AW));
    mk   = i * 1024 + int'((off >> 3) & ((64'd1 << AW) - 64'd1));
    old  = mmem.exists(mk) ? mmem[mk] : 64'hx;
    rdat = 64'd0;
    if (inr) begin
      if (r.strobe != 8'h00) begin
        pend_v[i]   = 1'b1;
        pend_had[i] = mmem.exists(mk);
        pend_old[i] = old;
        pend_key[i] = mk;
        pend_cyc[i] = c + lat + 1;
        rdat        = merge(old, r.strobe, r.data);
        mmem[mk]    = rdat;
      end else begin
        rdat = old;
      end
    end else begin
      if (m_err[i] != 16'hFFFF) m_err[i] = m_err[i] + 16'd1;
      e_err[key(i, c + lat + 1)] = m_err[i];
    end
    for (int j = c + 1; j <= c + lat; j++) e_busy[key(i, j)] = 1'b1;
    e_dok[key(i, c + lat)]  = 1'b1;
    e_data[key(i, c + lat)] = rdat;
    free_at[i] = c + lat + 1;
  endfunction

  // A reset seen in cycle c wipes everything the model had planned after it.
  function automatic void model_reset(input int c);
    for (int i = 0; i < 2; i++) begin
      for (int j = c + 1; j <= c + 20; j++) begin
        e_busy.delete(key(i, j));
        e_dok.delete(key(i, j));
        e_data.delete(key(i, j));
        e_err.delete(key(i, j));
      end
      e_err[key(i, c + 1)] = 16'd0;
      m_err[i]   = 16'd0;
      free_at[i] = c + 1;
      if (pend_v[i] && pend_cyc[i] > c) begin
        if (pend_had[i]) mmem[pend_key[i]] = pend_old[i];
        else mmem.delete(pend_key[i]);
      end
      pend_v[i] = 1'b0;
    end
  endfunction

  // ---------------- scoreboard: compare, then advance the model ----------------
  always @(negedge clk) begin : cmp
    int          k;
    logic        exp_busy;
    logic        exp_dok;
    logic [63:0] exp_data;
    dbus_resp_t  act;
    logic        act_busy;
    logic [15:0] act_err;
    if (seen_rst) begin
      for (int i = 0; i < 2; i++) begin
        k = key(i, cyc);
        if (e_err.exists(k)) cur_err[i] = e_err[k];
        exp_busy = e_busy.exists(k);
        exp_dok  = e_dok.exists(k);
        exp_data = e_data.exists(k) ? e_data[k] : 64'd0;
        act      = (i == 0) ? dresp0 : dresp1;
        act_busy = (i == 0) ? busy0 : busy1;
        act_err  = (i == 0) ? err0 : err1;
        check($sformatf("m%0d_busy@%0d", i, cyc), act_busy, exp_busy);
        check($sformatf("m%0d_data_ok@%0d", i, cyc), act.data_ok, exp_dok);
        check($sformatf("m%0d_addr_ok@%0d", i, cyc), act.addr_ok, exp_dok);
        check($sformatf("m%0d_data@%0d", i, cyc), act.data, exp_data);
        check($sformatf("m%0d_err@%0d", i, cyc), act_err, cur_err[i]);
      end
    end
    if (reset) begin
      model_reset(cyc);
      seen_rst = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_of(i).valid && cyc >= free_at[i]) model_accept(i, cyc, req_of(i));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bus(input int i, input logic v, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d);
    dbus_req_t r;
    r        = '0;
    r.valid  = v;
    r.addr   = a;
    r.size   = 3'd3;
    r.strobe = s;
    r.data   = d;
    if (i == 0) dreq0 = r;
    else dreq1 = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for data_ok; n counts cycles since acceptance.
  task automatic wait_dok(input int i, output logic [63:0] rd, output int lat);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    lat  = 0;
    rd   = '0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (dok_of(i)) begin
        done = 1'b1;
        lat  = n;
        rd   = data_of(i);
      end
    end
    check($sformatf("dok_seen_m%0d", i), done, 1'b1);
  endtask

  // One request: valid for a single cycle, then wait for its response.
  task automatic do_req(input int i, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, output logic [63:0] rd, output int lat);
    set_bus(i, 1'b1, a, s, d);
    next_cycle();
    set_bus(i, 1'b0, '0, '0, '0);
    wait_dok(i, rd, lat);
    next_cycle();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [63:0] rd;
    int          lat;
    int          dok_hits;

    set_bus(0, 1'b0, '0, '0, '0);
    set_bus(1, 1'b0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values.
    @(negedge clk);
    check("rst_ok0", {dresp0.addr_ok, dresp0.data_ok}, 2'b00);
    check("rst_data0", dresp0.data, 64'd0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_err0", err0, 16'd0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_err1", err1, 16'd0);
    next_cycle();

    // Full write then read back, LATENCY 2.
    do_req(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, rd, lat);
    check("wr_latency", lat, 2);
    check("wr_resp_data", rd, 64'h1122_3344_5566_7788);
    do_req(0, 64'h8000_0010, 8'h00, 64'd0, rd, lat);
    check("rd_latency", lat, 2);
    check("rd_back", rd, 64'h1122_3344_5566_7788);

    // Single-byte strobe merge.
    do_req(0, 64'h8000_0020, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, lat);
    do_req(0, 64'h8000_0020, 8'b0000_0100, 64'h0000_0000_00AB_0000, rd, lat);
    check("strobe_resp", rd, 64'hFFFF_FFFF_FFAB_FFFF);
    do_req(0, 64'h8000_0020, 8'h00, 64'd0, rd, lat);
    check("strobe_rd", rd, 64'hFFFF_FFFF_FFAB_FFFF);

    // Out of range below and above; the upper one aliases word 0 if truncated.
    do_req(0, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, lat);
    do_req(0, BASE - 64'd8, 8'h00, 64'd0, rd, lat);
    check("oor_low_data", rd, 64'd0);
    check("oor_low_err", err0, 16'd1);
    do_req(0, BASE + 64'd128, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, lat);
    check("oor_high_data", rd, 64'd0);
    check("oor_high_err", err0, 16'd2);
    do_req(0, 64'h8000_0000, 8'h00, 64'd0, rd, lat);
    check("oor_no_alias", rd, 64'h0123_4567_89AB_CDEF);

    // Request ownership: valid stays high with new fields until after data_ok.
    do_req(0, 64'h8000_0038, 8'hFF, 64'h3838_3838_3838_3838, rd, lat);
    set_bus(0, 1'b1, 64'h8000_0030, 8'hFF, 64'hCAFE_F00D_1234_5678);
    next_cycle();
    set_bus(0, 1'b1, 64'h8000_0038, 8'h0F, 64'h9999_9999_9999_9999);
    wait_dok(0, rd, lat);
    check("own_latency", lat, 2);
    check("own_resp", rd, 64'hCAFE_F00D_1234_5678);
    next_cycle();
    set_bus(0, 1'b0, '0, '0, '0);
    do_req(0, 64'h8000_0030, 8'h00, 64'd0, rd, lat);
    check("own_rd_a", rd, 64'hCAFE_F00D_1234_5678);
    do_req(0, 64'h8000_0038, 8'h00, 64'd0, rd, lat);
    check("own_rd_b", rd, 64'h3838_3838_3838_3838);

    // Back-to-back reads with LATENCY 1, valid held high throughout.
    do_req(1, 64'h8000_0008, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, rd, lat);
    check("l1_latency", lat, 1);
    do_req(1, 64'h8000_0018, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, rd, lat);
    set_bus(1, 1'b1, 64'h8000_0008, 8'h00, 64'd0);
    @(negedge clk);
    check("b2b_t_busy", busy1, 1'b0);
    next_cycle();
    set_bus(1, 1'b1, 64'h8000_0018, 8'h00, 64'd0);
    @(negedge clk);
    check("b2b_t1_dok", dresp1.data_ok, 1'b1);
    check("b2b_t1_data", dresp1.data, 64'hA5A5_A5A5_A5A5_A5A5);
    check("b2b_t1_busy", busy1, 1'b1);
    next_cycle();
    @(negedge clk);
    check("b2b_t2_dok", dresp1.data_ok, 1'b0);
    check("b2b_t2_busy", busy1, 1'b0);
    next_cycle();
    set_bus(1, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("b2b_t3_dok", dresp1.data_ok, 1'b1);
    check("b2b_t3_data", dresp1.data, 64'h5A5A_5A5A_5A5A_5A5A);
    check("b2b_t3_busy", busy1, 1'b1);
    next_cycle();

    // Reset while a write is waiting.
    do_req(0, 64'h8000_0040, 8'hFF, 64'd0, rd, lat);
    set_bus(0, 1'b1, 64'h8000_0040, 8'hFF, 64'h0000_0000_0000_DEAD);
    next_cycle();
    set_bus(0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rstw_ok", {dresp0.addr_ok, dresp0.data_ok}, 2'b00);
    check("rstw_data", dresp0.data, 64'd0);
    check("rstw_busy", busy0, 1'b0);
    check("rstw_err", err0, 16'd0);
    dok_hits = 0;
    for (int n = 0; n < 4; n++) begin
      next_cycle();
      @(negedge clk);
      if (dresp0.data_ok) dok_hits++;
    end
    check("rstw_no_dok", dok_hits, 0);
    next_cycle();
    do_req(0, 64'h8000_0040, 8'h00, 64'd0, rd, lat);
    check("rstw_rd", rd, 64'd0);

    repeat (3) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something wedges the driver.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
